approx_adder_mae_monitor: RTL and testbench

Sequential error-characterisation engine for the approximate ripple-carry adders in the adder library. It drives every operand pair of a WIDTH-bit adder under test into a purely combinational DUT and reads back the DUT's (WIDTH+1)-bit sum. Against the exact sum it accumulates error count, worst-case error and the sum of absolute errors, from which MAE is derived. It sits in the characterisation harness beside the DUT and replaces off-line simulation sweeps.

---
 rtl/approx_adder_mae_monitor.sv | 174 +++++++++++++++++
 tb/tb_approx_adder_mae_monitor.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_adder_mae_monitor.sv
// approx_adder_mae_monitor
//
// Purpose: sweeps every operand pair of a WIDTH-bit approximate adder that
// sits beside this block, one pair per clock. The adder sum is compared with
// the exact sum. The block accumulates:
//   - the error count,
//   - the worst-case error,
//   - the sum of absolute errors (MAE = sum_abs_err >> 2*WIDTH).
//
// Optional feature (macro MAE_MONITOR_WCE_ADDR_EN):
//   defined     -> wce_a/wce_b capture the operands of the first pair that
//                  reaches the worst-case error.
//   not defined -> the capture registers are absent and wce_a/wce_b read 0.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        single-cycle pulse, starts a sweep when not busy
//   a_out/b_out  registered operands driven to the adder under test
//   dut_sum      adder-under-test sum, combinational from a_out/b_out
//   busy/done    sweep in progress / sweep complete (results valid)
//   err_count    number of pairs with nonzero error
//   max_err      worst-case absolute error
//   sum_abs_err  sum of absolute errors
//   wce_a/wce_b  operands of the first worst-case pair
module approx_adder_mae_monitor #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  input  logic [WIDTH:0]       dut_sum,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH:0]     err_count,
  output logic [WIDTH:0]       max_err,
  output logic [3*WIDTH:0]     sum_abs_err,
  output logic [WIDTH-1:0]     wce_a,
  output logic [WIDTH-1:0]     wce_b
);

  localparam int EW = WIDTH + 1;
  localparam int CW = 2 * WIDTH + 1;
  localparam int SW = 3 * WIDTH + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [EW-1:0]    max_q, max_d;
  logic [SW-1:0]    sum_q, sum_d;

  logic [EW-1:0]    exact;
  logic [EW-1:0]    err;
  logic             clear;
  logic             new_max;

  always_comb begin
    exact   = EW'(a_q) + EW'(b_q);
    // Both sums are unsigned, so take the magnitude of the difference.
    err     = (exact >= dut_sum) ? (exact - dut_sum) : (dut_sum - exact);
    clear   = 1'b0;
    new_max = 1'b0;
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = RUN;
          a_d     = '0;
          b_d     = '0;
          cnt_d   = '0;
          max_d   = '0;
          sum_d   = '0;
        end
      end
      RUN: begin
        if (err != '0) cnt_d = cnt_q + CW'(1);
        sum_d = sum_q + SW'(err);
        if (err > max_q) begin
          new_max = 1'b1;
          max_d   = err;
        end
        // b is the fast index. On the final pair the operands are left at
        // all ones rather than wrapping.
        if (b_q == '1) begin
          if (a_q == '1) begin
            state_d = DONE;
          end else begin
            a_d = a_q + WIDTH'(1);
            b_d = '0;
          end
        end else begin
          b_d = b_q + WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      max_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      sum_q   <= sum_d;
    end
  end

`ifdef MAE_MONITOR_WCE_ADDR_EN
  logic [WIDTH-1:0] wa_q, wa_d;
  logic [WIDTH-1:0] wb_q, wb_d;

  // Strict comparison in new_max keeps the first pair that hits the maximum.
  always_comb begin
    wa_d = wa_q;
    wb_d = wb_q;
    if (clear) begin
      wa_d = '0;
      wb_d = '0;
    end else if (new_max) begin
      wa_d = a_q;
      wb_d = b_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wa_q <= '0;
      wb_q <= '0;
    end else begin
      wa_q <= wa_d;
      wb_q <= wb_d;
    end
  end

  assign wce_a = wa_q;
  assign wce_b = wb_q;
`else
  logic unused_capture;
  assign unused_capture = clear ^ new_max;
  assign wce_a = '0;
  assign wce_b = '0;
`endif

  assign a_out       = a_q;
  assign b_out       = b_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign err_count   = cnt_q;
  assign max_err     = max_q;
  assign sum_abs_err = sum_q;

endmodule

// File: tb/tb_approx_adder_mae_monitor.sv
// Testbench for approx_adder_mae_monitor.
//
// Two instances are used:
//   - A WIDTH=4 instance carries the sweep-by-sweep scenarios, which need
//     256 cycles per sweep.
//   - A WIDTH=8 instance runs one full constant-zero sweep in parallel.
//
// Expected results are pushed to per-instance queues when a sweep is
// launched. Each monitor pops an entry on the rising edge of done.
module tb_approx_adder_mae_monitor;

  typedef struct {
    longint ec;
    longint me;
    longint sae;
    longint wa;
    longint wb;
    longint cyc;
  } exp_t;

`ifdef MAE_MONITOR_WCE_ADDR_EN
  localparam bit WCE_ON = 1'b1;
`else
  localparam bit WCE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // ---------------- WIDTH=4 instance ----------------
  logic       rst_n  = 1'b0;
  logic       start4 = 1'b0;
  logic [3:0] a4, b4, wa4, wb4;
  logic [4:0] sum4, me4;
  logic [8:0] ec4;
  logic [12:0] sae4;
  logic       busy4, done4;
  int         mode = 0;
  logic [4:0] exact4;

  always_comb begin
    exact4 = {1'b0, a4} + {1'b0, b4};
    case (mode)
      1:       sum4 = exact4 & 5'b11110;
      2:       sum4 = 5'd0;
      3:       sum4 = exact4 + 5'd1;
      default: sum4 = exact4;
    endcase
  end

  approx_adder_mae_monitor #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .a_out(a4), .b_out(b4), .dut_sum(sum4),
    .busy(busy4), .done(done4),
    .err_count(ec4), .max_err(me4), .sum_abs_err(sae4),
    .wce_a(wa4), .wce_b(wb4)
  );

  // ---------------- WIDTH=8 instance ----------------
  logic        rst8_n = 1'b0;
  logic        start8 = 1'b0;
  logic [7:0]  a8, b8, wa8, wb8;
  logic [8:0]  sum8, me8;
  logic [16:0] ec8;
  logic [24:0] sae8;
  logic        busy8, done8;

  assign sum8 = 9'd0;

  approx_adder_mae_monitor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst8_n), .start(start8),
    .a_out(a8), .b_out(b8), .dut_sum(sum8),
    .busy(busy8), .done(done8),
    .err_count(ec8), .max_err(me8), .sum_abs_err(sae8),
    .wce_a(wa8), .wce_b(wb8)
  );

  exp_t q4[$];
  exp_t q8[$];
  bit   done8_seen = 1'b0;

  // Monitor for the WIDTH=4 instance.
  initial begin
    longint cyc = 0;
    bit     prev = 1'b0;
    exp_t   e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cyc  = 0;
        prev = 1'b0;
      end else begin
        if (busy4) cyc++;
        if (done4 && !prev) begin
          if (q4.size() == 0) begin
            chk("w4_unexpected_done", 1, 0);
          end else begin
            e = q4.pop_front();
            chk("w4_err_count", ec4, e.ec);
            chk("w4_max_err", me4, e.me);
            chk("w4_sum_abs_err", sae4, e.sae);
            chk("w4_wce_a", wa4, e.wa);
            chk("w4_wce_b", wb4, e.wb);
            chk("w4_run_cycles", cyc, e.cyc);
            chk("w4_a_hold", a4, 15);
            chk("w4_b_hold", b4, 15);
          end
          cyc = 0;
        end
        prev = done4;
      end
    end
  end

  // Monitor for the WIDTH=8 instance.
  initial begin
    longint cyc = 0;
    bit     prev = 1'b0;
    exp_t   e;
    forever begin
      @(negedge clk);
      if (rst8_n) begin
        if (busy8) cyc++;
        if (done8 && !prev) begin
          if (q8.size() == 0) begin
            chk("w8_unexpected_done", 1, 0);
          end else begin
            e = q8.pop_front();
            chk("w8_err_count", ec8, e.ec);
            chk("w8_max_err", me8, e.me);
            chk("w8_sum_abs_err", sae8, e.sae);
            chk("w8_wce_a", wa8, e.wa);
            chk("w8_wce_b", wb8, e.wb);
            chk("w8_run_cycles", cyc, e.cyc);
            chk("w8_a_hold", a8, 255);
            chk("w8_b_hold", b8, 255);
          end
          done8_seen = 1'b1;
          cyc = 0;
        end
        prev = done8;
      end
    end
  end

  function automatic exp_t mk(longint ec, longint me, longint sae,
                              longint wa, longint wb, longint cyc);
    exp_t e;
    e.ec  = ec;
    e.me  = me;
    e.sae = sae;
    e.wa  = WCE_ON ? wa : 0;
    e.wb  = WCE_ON ? wb : 0;
    e.cyc = cyc;
    return e;
  endfunction

  task automatic pulse_start4();
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic wait_done4(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done4) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({name, "_timeout"}, 0, 1);
    @(negedge clk);
  endtask

  task automatic sweep4(input int m, input exp_t e, input string name);
    mode = m;
    q4.push_back(e);
    pulse_start4();
    wait_done4(name);
  endtask

  task automatic chk_all_zero4(input string tag);
    chk({tag, "_busy"}, busy4, 0);
    chk({tag, "_done"}, done4, 0);
    chk({tag, "_a"}, a4, 0);
    chk({tag, "_b"}, b4, 0);
    chk({tag, "_ec"}, ec4, 0);
    chk({tag, "_me"}, me4, 0);
    chk({tag, "_sae"}, sae4, 0);
    chk({tag, "_wa"}, wa4, 0);
    chk({tag, "_wb"}, wb4, 0);
  endtask

  // The WIDTH=8 constant-zero sweep runs alongside everything else.
  initial begin
    repeat (2) @(negedge clk);
    rst8_n = 1'b1;
    @(negedge clk);
    q8.push_back(mk(65535, 510, 16711680, 255, 255, 65536));
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  end

  initial begin
    // Reset state while reset is held, then while idle after release.
    #1;
    chk_all_zero4("in_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero4("idle");

    sweep4(0, mk(0, 0, 0, 0, 0, 256), "exact");
    sweep4(1, mk(128, 1, 128, 0, 1, 256), "bit0");
    sweep4(2, mk(255, 30, 3840, 15, 15, 256), "zero");
    sweep4(3, mk(256, 1, 256, 0, 0, 256), "plus1");

    // A second start during RUN must be ignored.
    mode = 2;
    q4.push_back(mk(255, 30, 3840, 15, 15, 256));
    pulse_start4();
    repeat (100) @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wait_done4("restart_ignored");

    // Reset mid-sweep clears everything at once and needs a fresh start.
    mode = 1;
    pulse_start4();
    repeat (100) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero4("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_all_zero4("after_reset");
    sweep4(1, mk(128, 1, 128, 0, 1, 256), "fresh");

    // Wait for the WIDTH=8 sweep to complete.
    for (int i = 0; i < 70000; i++) begin
      if (done8_seen) break;
      @(negedge clk);
    end
    if (!done8_seen) chk("w8_timeout", 0, 1);
    repeat (2) @(negedge clk);
    chk("w4_queue_empty", q4.size(), 0);
    chk("w8_queue_empty", q8.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
